// File: rtl/double_dabble_pkg.sv
`default_nettype none
// ============================================================================
// Module      : double_dabble_pkg
// Description : Shared types and constants for the reverse double dabble
//               (BCD-to-binary) converter.
// Revision    : 1.0 - initial release
// ============================================================================
package double_dabble_pkg;

   // Width of one packed BCD digit
   localparam int DD_BCD_DIGIT_W = 4;

   // Converter FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } dd_rev_state_t;

   // Minimum binary width able to hold 10^digits - 1
   function automatic int dd_bin_width(input int digits);
      longint unsigned max_val;
      int              width;
      max_val = 64'd1;
      for (int i = 0; i < digits; i++) begin
         max_val = max_val * 64'd10;
      end
      max_val = max_val - 64'd1;
      width   = 0;
      for (int i = 0; i < 64; i++) begin
         if ((64'd1 << i) <= max_val) begin
            width = i + 1;
         end
      end
      return width;
   endfunction

endpackage
`default_nettype wire

// File: rtl/double_dabble_reverse_if.sv
`default_nettype none
// ============================================================================
// Module      : double_dabble_reverse_if
// Description : Input (BCD) and output (binary) valid/ready handshakes of the
//               reverse double dabble converter. The converter uses the slave
//               modport, the driving/consuming environment the master one.
// Revision    : 1.0 - initial release
// ============================================================================
interface double_dabble_reverse_if
   import double_dabble_pkg::*;
#(
   parameter int Digit_Count      = 4,
   parameter int Output_Bit_Width = 14
);

   logic [DD_BCD_DIGIT_W*Digit_Count-1:0] bcd_input;
   logic                                  valid_input;
   logic                                  ready_input;
   logic [Output_Bit_Width-1:0]           binary_output;
   logic                                  valid_output;
   logic                                  ready_output;
   logic                                  error_output;

   modport master (
      output bcd_input,
      output valid_input,
      input  ready_input,
      input  binary_output,
      input  valid_output,
      output ready_output,
      input  error_output
   );

   modport slave (
      input  bcd_input,
      input  valid_input,
      output ready_input,
      output binary_output,
      output valid_output,
      input  ready_output,
      output error_output
   );

endinterface
`default_nettype wire

// File: rtl/double_dabble_reverse_cell.sv
`default_nettype none
// ============================================================================
// Module      : double_dabble_reverse_cell
// Description : Per-digit correction for reverse double dabble: a digit that
//               is 8 or more after the right shift has 3 subtracted. Inputs
//               below 8 pass through, so the result never underflows.
// Revision    : 1.0 - initial release
// ============================================================================
module double_dabble_reverse_cell
   import double_dabble_pkg::*;
(
   input  wire logic [DD_BCD_DIGIT_W-1:0] digit_in,
   output      logic [DD_BCD_DIGIT_W-1:0] digit_out
);

   assign digit_out = (digit_in >= 4'd8) ? (digit_in - 4'd3) : digit_in;

endmodule
`default_nettype wire

// File: rtl/double_dabble_reverse.sv
`default_nettype none
// ============================================================================
// Module      : double_dabble_reverse
// Description : Sequential BCD-to-binary converter (reverse double dabble).
//               Accepts a packed BCD word, performs one shift-right/correct
//               step per enabled clock for Output_Bit_Width steps, then holds
//               the binary result until the downstream handshake.
//               Optional macro DOUBLE_DABBLE_REVERSE_CHECK_EN: flags inputs
//               containing a digit > 9 and forces the result to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module double_dabble_reverse
   import double_dabble_pkg::*;
#(
   parameter int Digit_Count      = 4,
   parameter int Output_Bit_Width = 14
)(
   input wire logic               clk,
   input wire logic               async_rst_n,
   input wire logic               clk_en,
   double_dabble_reverse_if.slave bus
);

   localparam int c_bcd_w = DD_BCD_DIGIT_W * Digit_Count;
   localparam int c_cnt_w = $clog2(Output_Bit_Width + 1);
   localparam logic [c_cnt_w-1:0] c_last_iter = c_cnt_w'(Output_Bit_Width - 1);

   // Result width must cover the largest BCD value
   generate
      if (Output_Bit_Width < dd_bin_width(Digit_Count)) begin : g_width_check
         $error("Output_Bit_Width too small for Digit_Count");
      end
   endgenerate

   dd_rev_state_t               r_state;
   dd_rev_state_t               w_next_state;
   logic [c_bcd_w-1:0]          r_bcd;
   logic [c_bcd_w-1:0]          w_bcd_shift;
   logic [c_bcd_w-1:0]          w_bcd_corr;
   logic [Output_Bit_Width-1:0] r_bin;
   logic [c_cnt_w-1:0]          r_cnt;

   // BCD half of the working register after the right shift; its LSB moves
   // into the binary MSB
   assign w_bcd_shift = r_bcd >> 1;

   generate
      for (genvar gi = 0; gi < Digit_Count; gi++) begin : g_cell
         double_dabble_reverse_cell u_cell (
            .digit_in  (w_bcd_shift[gi*DD_BCD_DIGIT_W +: DD_BCD_DIGIT_W]),
            .digit_out (w_bcd_corr[gi*DD_BCD_DIGIT_W +: DD_BCD_DIGIT_W])
         );
      end
   endgenerate

   // FSM state register
   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         r_state <= IDLE;
      end else if (clk_en) begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic and handshake decodes of the registered state
   always_comb begin
      w_next_state     = r_state;
      bus.ready_input  = 1'b0;
      bus.valid_output = 1'b0;
      case (r_state)
         IDLE: begin
            bus.ready_input = 1'b1;
            if (bus.valid_input) begin
               w_next_state = SHIFT;
            end
         end
         SHIFT: begin
            if (r_cnt == c_last_iter) begin
               w_next_state = DONE;
            end
         end
         DONE: begin
            bus.valid_output = 1'b1;
            if (bus.ready_output) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Working register and iteration counter: load on acceptance, step in SHIFT
   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         r_bcd <= '0;
         r_bin <= '0;
         r_cnt <= '0;
      end else if (clk_en) begin
         case (r_state)
            IDLE: begin
               if (bus.valid_input) begin
                  r_bcd <= bus.bcd_input;
                  r_bin <= '0;
                  r_cnt <= '0;
               end
            end
            SHIFT: begin
               r_bcd <= w_bcd_corr;
               r_bin <= {r_bcd[0], r_bin[Output_Bit_Width-1:1]};
               r_cnt <= r_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef DOUBLE_DABBLE_REVERSE_CHECK_EN
   logic r_err;
   logic w_bad_digit;

   // Detect any non-decimal digit in the offered word
   always_comb begin
      w_bad_digit = 1'b0;
      for (int d = 0; d < Digit_Count; d++) begin
         if (bus.bcd_input[d*DD_BCD_DIGIT_W +: DD_BCD_DIGIT_W] > 4'd9) begin
            w_bad_digit = 1'b1;
         end
      end
   end

   // Error flag is captured once at acceptance and kept for the conversion
   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         r_err <= 1'b0;
      end else if (clk_en && (r_state == IDLE) && bus.valid_input) begin
         r_err <= w_bad_digit;
      end
   end

   assign bus.error_output  = r_err && (r_state == DONE);
   assign bus.binary_output = r_err ? '0 : r_bin;
`else
   assign bus.error_output  = 1'b0;
   assign bus.binary_output = r_bin;
`endif

endmodule
`default_nettype wire

// File: tb/tb_double_dabble_reverse.sv
`default_nettype none
// ============================================================================
// Module      : tb_double_dabble_reverse
// Description : Directed self-checking bench for double_dabble_reverse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_double_dabble_reverse;

   localparam int DIGITS = 4;
   localparam int WIDTH  = 14;

   logic clk         = 1'b0;
   logic async_rst_n = 1'b1;
   logic clk_en      = 1'b0;
   int   n_checks    = 0;
   int   n_pass      = 0;
   int   cycles;
   bit   saw_ready;
   int   stable;

   double_dabble_reverse_if #(.Digit_Count(DIGITS), .Output_Bit_Width(WIDTH)) bus ();

   double_dabble_reverse #(
      .Digit_Count      (DIGITS),
      .Output_Bit_Width (WIDTH)
   ) dut (
      .clk         (clk),
      .async_rst_n (async_rst_n),
      .clk_en      (clk_en),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end else begin
         n_pass++;
      end
   endtask

   // Offer a word once the converter is idle; returns #1 after the accept edge
   task automatic send(input logic [15:0] bcd);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!bus.ready_input && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      bus.bcd_input   = bcd;
      bus.valid_input = 1'b1;
      clk_en          = 1'b1;
      @(posedge clk);
      #1;
      bus.valid_input = 1'b0;
   endtask

   // Count enabled edges until valid_output; optionally toggle clk_en
   task automatic wait_result(input bit toggle_en, output int n_en, output bit ready_seen);
      n_en       = 0;
      ready_seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         if (clk_en) n_en++;
         #1;
         if (bus.ready_input) ready_seen = 1'b1;
         if (bus.valid_output) break;
         if (toggle_en) clk_en = ~clk_en;
      end
      clk_en = 1'b1;
   endtask

   initial begin
      bus.bcd_input    = '0;
      bus.valid_input  = 1'b0;
      bus.ready_output = 1'b1;

      // Reset state
      #1 async_rst_n = 1'b0;
      #2;
      check("rst_ready_input",  32'(bus.ready_input),   32'd1);
      check("rst_valid_output", 32'(bus.valid_output),  32'd0);
      check("rst_binary",       32'(bus.binary_output), 32'd0);
      check("rst_error",        32'(bus.error_output),  32'd0);
      repeat (2) @(negedge clk);
      async_rst_n = 1'b1;
      clk_en      = 1'b1;

      // 9999 -> 270F, latency 14
      send(16'h9999);
      wait_result(1'b0, cycles, saw_ready);
      check("9999_latency", 32'(cycles),            32'd14);
      check("9999_binary",  32'(bus.binary_output), 32'h270F);
      check("9999_error",   32'(bus.error_output),  32'd0);
      check("9999_ready",   32'(saw_ready),         32'd0);
      @(posedge clk); #1;
      check("9999_consumed", 32'(bus.valid_output), 32'd0);

      // 1234 then 0000 offered back-to-back
      send(16'h1234);
      wait_result(1'b0, cycles, saw_ready);
      check("1234_binary", 32'(bus.binary_output), 32'h04D2);
      check("1234_ready",  32'(saw_ready),         32'd0);
      bus.bcd_input   = 16'h0000;
      bus.valid_input = 1'b1;
      @(posedge clk); #1;
      check("noskid_ready_input", 32'(bus.ready_input),  32'd1);
      check("noskid_valid",       32'(bus.valid_output), 32'd0);
      @(posedge clk); #1;
      check("0000_accepted", 32'(bus.ready_input), 32'd0);
      bus.valid_input = 1'b0;
      wait_result(1'b0, cycles, saw_ready);
      check("0000_latency", 32'(cycles),            32'd14);
      check("0000_binary",  32'(bus.binary_output), 32'h0000);
      @(posedge clk); #1;

      // 0500 with downstream stalled for 10 cycles
      bus.ready_output = 1'b0;
      send(16'h0500);
      wait_result(1'b0, cycles, saw_ready);
      stable = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (bus.valid_output && bus.binary_output == 14'h01F4) stable++;
      end
      check("0500_hold_cycles", 32'(stable), 32'd10);
      bus.ready_output = 1'b1;
      @(posedge clk); #1;
      check("0500_released_valid", 32'(bus.valid_output), 32'd0);
      check("0500_released_idle",  32'(bus.ready_input),  32'd1);

      // 0042 with clk_en toggling
      send(16'h0042);
      wait_result(1'b1, cycles, saw_ready);
      check("0042_enabled_cycles", 32'(cycles),            32'd14);
      check("0042_binary",         32'(bus.binary_output), 32'h002A);
      @(posedge clk); #1;

      // Word with a non-decimal digit
      send(16'h12A4);
      wait_result(1'b0, cycles, saw_ready);
      check("12A4_latency", 32'(cycles), 32'd14);
`ifdef DOUBLE_DABBLE_REVERSE_CHECK_EN
      check("12A4_error",  32'(bus.error_output),  32'd1);
      check("12A4_binary", 32'(bus.binary_output), 32'd0);
`else
      check("12A4_error",  32'(bus.error_output),  32'd0);
`endif
      @(posedge clk); #1;

      // Asynchronous reset in the middle of a conversion
      send(16'h9999);
      repeat (7) @(posedge clk);
      #1 async_rst_n = 1'b0;
      #1;
      check("midrst_ready_input", 32'(bus.ready_input),   32'd1);
      check("midrst_valid",       32'(bus.valid_output),  32'd0);
      check("midrst_binary",      32'(bus.binary_output), 32'd0);
      @(negedge clk);
      async_rst_n = 1'b1;
      send(16'h0001);
      wait_result(1'b0, cycles, saw_ready);
      check("0001_latency", 32'(cycles),            32'd14);
      check("0001_binary",  32'(bus.binary_output), 32'h0001);
      @(posedge clk); #1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
